// File: rtl/axi_bresp_arb_if.sv
// Bundles the per-source B inputs, the shared upstream B port and the error counter
// of axi_bresp_arb; slave is the arbiter side, master is the side that drives it.
interface axi_bresp_arb_if #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int ERR_W   = 16
);
  logic [4*NUM_SRC-1:0] in_mbid;
  logic [2*NUM_SRC-1:0] in_mbresp;
  logic [2*NUM_SRC-1:0] in_mbuser;
  logic [NUM_SRC-1:0]   in_mbvalid;
  logic [NUM_SRC-1:0]   out_mbready;
  logic [3:0]           out_sbid;
  logic [1:0]           out_sbresp;
  logic [1:0]           out_sbuser;
  logic [SRC_W-1:0]     out_sbsrc;
  logic                 out_sbvalid;
  logic                 in_sbready;
  logic                 in_err_clr;
  logic [ERR_W-1:0]     out_err_cnt;

  modport slave (
    input  in_mbid, in_mbresp, in_mbuser, in_mbvalid, in_sbready, in_err_clr,
    output out_mbready, out_sbid, out_sbresp, out_sbuser, out_sbsrc, out_sbvalid,
           out_err_cnt
  );

  modport master (
    output in_mbid, in_mbresp, in_mbuser, in_mbvalid, in_sbready, in_err_clr,
    input  out_mbready, out_sbid, out_sbresp, out_sbuser, out_sbsrc, out_sbvalid,
           out_err_cnt
  );
endinterface

// File: rtl/axi_bresp_arb.sv
// Round-robin merge of NUM_SRC AXI B sources into one registered upstream B port,
// with a source tag and a saturating count of delivered SLVERR/DECERR beats.
module axi_bresp_arb #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int ERR_W   = 16
) (
  input  logic           clk,
  input  logic           reset_,
  axi_bresp_arb_if.slave bus
);

  logic [3:0]       src_bid  [NUM_SRC];
  logic [1:0]       src_resp [NUM_SRC];
  logic [1:0]       src_user [NUM_SRC];

  logic             sbvalid_q, sbvalid_d;
  logic [3:0]       sbid_q, sbid_d;
  logic [1:0]       sbresp_q, sbresp_d;
  logic [1:0]       sbuser_q, sbuser_d;
  logic [SRC_W-1:0] sbsrc_q, sbsrc_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             load;
  logic             out_hs;
  logic             src_hs;
  logic             gnt_vld;
  logic [SRC_W-1:0] gnt;
  logic [SRC_W-1:0] arb_idx;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_bid[gi]         = bus.in_mbid[4*gi +: 4];
    assign src_resp[gi]        = bus.in_mbresp[2*gi +: 2];
    assign src_user[gi]        = bus.in_mbuser[2*gi +: 2];
    assign bus.out_mbready[gi] = src_hs && (gnt == SRC_W'(gi));
  end

  assign load   = ~sbvalid_q | bus.in_sbready;
  assign out_hs = sbvalid_q & bus.in_sbready;
  // Gate with reset_ so no source sees a handshake that the held-in-reset slice would drop.
  assign src_hs = load & gnt_vld & reset_;

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    arb_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      arb_idx = SRC_W'((int'(last_grant_q) + k) % NUM_SRC);
      if (bus.in_mbvalid[arb_idx]) begin
        gnt     = arb_idx;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sbvalid_d    = sbvalid_q;
    sbid_d       = sbid_q;
    sbresp_d     = sbresp_q;
    sbuser_d     = sbuser_q;
    sbsrc_d      = sbsrc_q;
    last_grant_d = last_grant_q;
    err_cnt_d    = err_cnt_q;

    if (src_hs) begin
      sbvalid_d    = 1'b1;
      sbid_d       = src_bid[gnt];
      sbresp_d     = src_resp[gnt];
      sbuser_d     = src_user[gnt];
      sbsrc_d      = gnt;
      last_grant_d = gnt;
    end else if (out_hs) begin
      sbvalid_d = 1'b0;
    end

    // Clear has priority; resp[1] set means SLVERR or DECERR.
    if (bus.in_err_clr) begin
      err_cnt_d = '0;
    end else if (out_hs && sbresp_q[1] && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      sbvalid_q    <= 1'b0;
      sbid_q       <= '0;
      sbresp_q     <= '0;
      sbuser_q     <= '0;
      sbsrc_q      <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      err_cnt_q    <= '0;
    end else begin
      sbvalid_q    <= sbvalid_d;
      sbid_q       <= sbid_d;
      sbresp_q     <= sbresp_d;
      sbuser_q     <= sbuser_d;
      sbsrc_q      <= sbsrc_d;
      last_grant_q <= last_grant_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.out_sbvalid = sbvalid_q;
  assign bus.out_sbid    = sbid_q;
  assign bus.out_sbresp  = sbresp_q;
  assign bus.out_sbuser  = sbuser_q;
  assign bus.out_sbsrc   = sbsrc_q;
  assign bus.out_err_cnt = err_cnt_q;

endmodule
